// File: rtl/cpu_pkg.sv
// Shared constants and FSM encoding for the boot loader slice.
package cpu_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int WORD_DEPTH = 4096;
  localparam int WORD_WIDTH = 16;
  localparam int BYTE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } state_t;

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Byte-stream handshake and big-endian pairing of bytes into sram words.
module byte_packer
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic                  i_clear,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic [WORD_WIDTH-1:0] o_word,
  output logic                  o_word_ready
);

  logic                  phase_hi_q;
  logic [BYTE_WIDTH-1:0] hi_byte_q;
  logic                  accept;

  assign o_byte_ready = i_en;
  assign accept       = i_en & i_byte_valid;
  // The low byte is taken straight off the bus so the word is complete on the accepting edge.
  assign o_word       = {hi_byte_q, i_byte};
  assign o_word_ready = accept & ~phase_hi_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_hi_q <= 1'b1;
      hi_byte_q  <= '0;
    end else if (i_clear) begin
      phase_hi_q <= 1'b1;
    end else if (accept) begin
      phase_hi_q <= ~phase_hi_q;
      if (phase_hi_q) hi_byte_q <= i_byte;
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Loads a byte stream into sram after reset, then hands the memory bus to the CPU.
module boot_loader
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_word_count,
  input  logic [BYTE_WIDTH-1:0] i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  input  logic [WORD_WIDTH-1:0] i_cpu_data,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic                  i_cpu_we,
  input  logic                  i_cpu_ce,
  output logic [WORD_WIDTH-1:0] o_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic                  o_mem_ce,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam logic [ADDR_WIDTH+1:0] DEPTH_EXT = (ADDR_WIDTH+2)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     cnt_q;
  logic                    error_q;
  logic                    cpu_rst_n_q;
  logic                    mem_wr_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [WORD_WIDTH-1:0]   mem_data_q;

  logic [ADDR_WIDTH+1:0]   end_addr;
  logic                    range_err;
  logic                    run;
  logic [WORD_WIDTH-1:0]   word;
  logic                    word_ready;

  byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_en         (state_q == LOAD),
    .i_clear      (state_q == IDLE),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .o_word       (word),
    .o_word_ready (word_ready)
  );

  // Widened so base+count cannot overflow before the bound is tested.
  assign end_addr  = {2'b00, i_base_addr} + {1'b0, i_word_count};
  assign range_err = end_addr > DEPTH_EXT;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_word_count == '0) state_d = RUN;
          else if (!range_err)    state_d = LOAD;
        end
      end
      LOAD:    if (word_ready) state_d = WRITE;
      WRITE:   state_d = (cnt_q == CNT_ONE) ? RUN : LOAD;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= (state_q == RUN);
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            addr_q  <= i_base_addr;
            cnt_q   <= i_word_count;
            error_q <= range_err;
          end
        end
        LOAD: begin
          // Stage the write so the sram sees registered signals during WRITE.
          if (word_ready) begin
            mem_wr_q   <= 1'b1;
            mem_addr_q <= addr_q;
            mem_data_q <= word;
          end
        end
        WRITE: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q != CNT_ONE) addr_q <= addr_q + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  assign run           = (state_q == RUN);
  assign o_mem_data    = run ? i_cpu_data : mem_data_q;
  assign o_mem_addr    = run ? i_cpu_addr : mem_addr_q;
  assign o_mem_we      = run ? i_cpu_we   : mem_wr_q;
  assign o_mem_ce      = run ? i_cpu_ce   : mem_wr_q;
  assign o_cpu_reset_n = cpu_rst_n_q;
  assign o_busy        = (state_q == LOAD) || (state_q == WRITE);
  assign o_done        = run;
  assign o_error       = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a behavioural sram on the memory port.
module tb_boot_loader;
  import cpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  i_start = 1'b0;
  logic [ADDR_WIDTH-1:0] i_base_addr = '0;
  logic [ADDR_WIDTH:0]   i_word_count = '0;
  logic [BYTE_WIDTH-1:0] i_byte = '0;
  logic                  i_byte_valid = 1'b0;
  logic                  o_byte_ready;
  logic [WORD_WIDTH-1:0] i_cpu_data = '0;
  logic [ADDR_WIDTH-1:0] i_cpu_addr = '0;
  logic                  i_cpu_we = 1'b0;
  logic                  i_cpu_ce = 1'b0;
  logic [WORD_WIDTH-1:0] o_mem_data;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic                  o_mem_we;
  logic                  o_mem_ce;
  logic                  o_cpu_reset_n;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_error;

  int vectors = 0;
  int miscompares = 0;

  boot_loader dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_base_addr   (i_base_addr),
    .i_word_count  (i_word_count),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .o_byte_ready  (o_byte_ready),
    .i_cpu_data    (i_cpu_data),
    .i_cpu_addr    (i_cpu_addr),
    .i_cpu_we      (i_cpu_we),
    .i_cpu_ce      (i_cpu_ce),
    .o_mem_data    (o_mem_data),
    .o_mem_addr    (o_mem_addr),
    .o_mem_we      (o_mem_we),
    .o_mem_ce      (o_mem_ce),
    .o_cpu_reset_n (o_cpu_reset_n),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 clk = ~clk;

  // Behavioural sram plus a write log.
  logic [15:0] mem [0:WORD_DEPTH-1];
  logic        mem_clr = 1'b0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          ready_in_write = 0;
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= 16'hdead;
      wr_cnt <= 0;
      ready_in_write <= 0;
      wr_cyc.delete();
    end else if (o_mem_ce && o_mem_we) begin
      mem[o_mem_addr] <= o_mem_data;
      wr_cnt <= wr_cnt + 1;
      wr_cyc.push_back(cyc);
      if (o_byte_ready) ready_in_write <= ready_in_write + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    mem_clr = 1'b1;
    tick();
    tick();
    mem_clr = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic start(input logic [ADDR_WIDTH-1:0] base, input logic [ADDR_WIDTH:0] count);
    i_base_addr  = base;
    i_word_count = count;
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    i_byte = b;
    i_byte_valid = 1'b1;
    for (int n = 0; n < 20 && !ok; n++) begin
      ok = o_byte_ready;
      tick();
    end
    check("byte_accept", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    #2 reset = 1'b1;
    #1;
    check("rst_ctrl", {25'd0, o_byte_ready, o_mem_we, o_mem_ce, o_busy, o_done, o_error, o_cpu_reset_n}, 32'd0);
    check("rst_addr", {20'd0, o_mem_addr}, 32'd0);
    check("rst_data", {16'd0, o_mem_data}, 32'd0);
    do_reset();

    // 1: reset pulse mid-LOAD after three bytes.
    start(12'd200, 13'd4);
    check("t1_busy", {31'd0, o_busy}, 32'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    #2 reset = 1'b1;
    #1;
    check("t1_rst_ctrl", {25'd0, o_byte_ready, o_mem_we, o_mem_ce, o_busy, o_done, o_error, o_cpu_reset_n}, 32'd0);
    check("t1_rst_addr", {20'd0, o_mem_addr}, 32'd0);
    tick();
    reset = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    i_byte_valid = 1'b0;
    check("t1_wr_cnt", wr_cnt, 32'd1);
    check("t1_mem200", {16'd0, mem[200]}, 32'h1234);
    check("t1_mem201", {16'd0, mem[201]}, 32'hdead);
    check("t1_idle", {30'd0, o_busy, o_byte_ready}, 32'd0);

    // 2: ten words with valid held high.
    do_reset();
    start(12'd100, 13'd10);
    for (int k = 1; k <= 10; k++) begin
      send_byte(8'h00);
      send_byte(8'(k));
    end
    check("t2_last_we", {31'd0, o_mem_we}, 32'd1);
    check("t2_last_addr", {20'd0, o_mem_addr}, 32'd109);
    tick();
    i_byte_valid = 1'b0;
    check("t2_done", {31'd0, o_done}, 32'd1);
    check("t2_cpu_rst_early", {31'd0, o_cpu_reset_n}, 32'd0);
    check("t2_wr_cnt", wr_cnt, 32'd10);
    tick();
    check("t2_cpu_rst", {31'd0, o_cpu_reset_n}, 32'd1);
    for (int k = 0; k < 10; k++) check("t2_mem", {16'd0, mem[100+k]}, 32'(k + 1));
    for (int k = 1; k < 10 && k < wr_cyc.size(); k++) check("t2_spacing", wr_cyc[k] - wr_cyc[k-1], 32'd3);

    // 3: same load with valid toggling.
    do_reset();
    start(12'd100, 13'd10);
    for (int k = 1; k <= 10; k++) begin
      send_byte(8'h00);
      i_byte_valid = 1'b0;
      tick();
      send_byte(8'(k));
      i_byte_valid = 1'b0;
      tick();
    end
    check("t3_done", {31'd0, o_done}, 32'd1);
    check("t3_wr_cnt", wr_cnt, 32'd10);
    check("t3_ready_in_write", ready_in_write, 32'd0);
    for (int k = 0; k < 10; k++) check("t3_mem", {16'd0, mem[100+k]}, 32'(k + 1));

    // 4: range error, then the largest legal load at the top of memory.
    do_reset();
    start(12'd4090, 13'd7);
    check("t4_error", {31'd0, o_error}, 32'd1);
    check("t4_idle", {29'd0, o_busy, o_done, o_byte_ready}, 32'd0);
    for (int n = 0; n < 3; n++) tick();
    check("t4_no_write", wr_cnt, 32'd0);
    check("t4_error_held", {31'd0, o_error}, 32'd1);
    start(12'd4090, 13'd6);
    check("t4_error_clr", {31'd0, o_error}, 32'd0);
    check("t4_busy", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      send_byte(8'hA0 + 8'(k));
      send_byte(8'h50 + 8'(k));
    end
    i_byte_valid = 1'b0;
    tick();
    check("t4_done", {31'd0, o_done}, 32'd1);
    check("t4_wr_cnt", wr_cnt, 32'd6);
    for (int k = 0; k < 6; k++) check("t4_mem", {16'd0, mem[4090+k]}, {16'd0, 8'hA0 + 8'(k), 8'h50 + 8'(k)});
    check("t4_mem0", {16'd0, mem[0]}, 32'hdead);

    // 5: zero-length load, then CPU owns the bus.
    do_reset();
    i_cpu_addr = 12'd99;
    i_cpu_data = 16'd55;
    i_cpu_we   = 1'b1;
    i_cpu_ce   = 1'b1;
    #1;
    check("t5_cpu_ignored", {30'd0, o_mem_we, o_mem_ce}, 32'd0);
    i_cpu_we = 1'b0;
    i_cpu_ce = 1'b0;
    start(12'd0, 13'd0);
    check("t5_run", {30'd0, o_done, o_busy}, 32'd2);
    check("t5_no_write", wr_cnt, 32'd0);
    i_cpu_we = 1'b1;
    i_cpu_ce = 1'b1;
    #1;
    check("t5_pass_addr", {20'd0, o_mem_addr}, 32'd99);
    tick();
    i_cpu_we = 1'b0;
    i_cpu_ce = 1'b0;
    check("t5_mem99", {16'd0, mem[99]}, 32'd55);
    check("t5_cpu_rst", {31'd0, o_cpu_reset_n}, 32'd1);

    // 6: a second start during LOAD is ignored.
    do_reset();
    start(12'd300, 13'd2);
    send_byte(8'hC1);
    i_byte_valid = 1'b0;
    start(12'd0, 13'd1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hC4);
    i_byte_valid = 1'b0;
    tick();
    check("t6_done", {31'd0, o_done}, 32'd1);
    check("t6_wr_cnt", wr_cnt, 32'd2);
    check("t6_mem300", {16'd0, mem[300]}, 32'hC1C2);
    check("t6_mem301", {16'd0, mem[301]}, 32'hC3C4);
    check("t6_mem0", {16'd0, mem[0]}, 32'hdead);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
Sits directly upstream of the sram, between the CPU bus and the memory write port. After reset it holds the CPU in reset and owns the memory bus. It accepts a byte stream over a valid/ready handshake, packs bytes into 16-bit words, and writes them to sequential sram addresses. When the programmed word count is written, it hands the bus to the CPU and releases the CPU reset.

Parameters:
- ADDR_WIDTH, 12, sram address width
- WORD_DEPTH, 4096, number of sram words
- WORD_WIDTH, 16, sram word width; must equal 2 × BYTE_WIDTH
- BYTE_WIDTH, 8, width of the input stream

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle load request; sampled only in IDLE
- i_base_addr  in  ADDR_WIDTH  first sram address written
- i_word_count  in  ADDR_WIDTH+1  number of words to load, 0..WORD_DEPTH
- i_byte  in  BYTE_WIDTH  stream data
- i_byte_valid  in  1  stream data valid
- o_byte_ready  out  1  loader accepts i_byte this cycle
- i_cpu_data  in  WORD_WIDTH  CPU write data
- i_cpu_addr  in  ADDR_WIDTH  CPU address
- i_cpu_we  in  1  CPU write enable
- i_cpu_ce  in  1  CPU chip enable
- o_mem_data  out  WORD_WIDTH  to sram i_data
- o_mem_addr  out  ADDR_WIDTH  to sram i_addr
- o_mem_we  out  1  to sram i_we
- o_mem_ce  out  1  to sram i_ce
- o_cpu_reset_n  out  1  active-low reset to the CPU
- o_busy  out  1  high in LOAD or WRITE
- o_done  out  1  high in RUN
- o_error  out  1  sticky range error

Behaviour:
Reset (asynchronous, any state, including mid-load):
- State goes to IDLE; byte/address/count registers clear.
- o_byte_ready=0, o_mem_we=0, o_mem_ce=0, o_mem_addr=0, o_mem_data=0.
- o_cpu_reset_n=0, o_busy=0, o_done=0, o_error=0.

States: IDLE, LOAD, WRITE, RUN.

IDLE:
- On i_start, latch base address and count.
  - Count=0: go to RUN.
  - base+count > WORD_DEPTH: set o_error, stay IDLE. The error clears on the next accepted start.
  - Otherwise: go to LOAD with byte phase = high.

LOAD:
- o_byte_ready=1. A byte is accepted when i_byte_valid and o_byte_ready are both high.
- Byte order is big-endian: the first byte fills bits [15:8], the second fills [7:0].
- On the second accepted byte, go to WRITE.
- No timeout: valid may stay low indefinitely.

WRITE (exactly one cycle):
- o_byte_ready=0.
- o_mem_ce=1, o_mem_we=1, o_mem_addr=current address, o_mem_data=assembled word. These are registered outputs.
- Then increment address, decrement remaining count.
  - Remaining=0: go to RUN.
  - Otherwise: go to LOAD.
- Peak throughput: 1 word per 3 cycles.

RUN:
- The mem outputs are a combinational pass-through of the i_cpu_* inputs.
- o_cpu_reset_n is registered and goes high on the first clock edge in RUN, so the CPU leaves reset one cycle after the bus switch.
- o_done=1. i_start is ignored; only reset leaves RUN.

Other rules:
- i_start in LOAD or WRITE is ignored.
- i_cpu_* inputs are ignored outside RUN.
- Address arithmetic is ADDR_WIDTH bits and never wraps, because the range check guarantees it.
- Count arithmetic is ADDR_WIDTH+1 bits, so count=4096 with base=0 is legal.

Decomposition:
- Shared package (cpu_pkg): ADDR_WIDTH, WORD_DEPTH, WORD_WIDTH, BYTE_WIDTH constants and the state encoding IDLE=2'd0, LOAD=2'd1, WRITE=2'd2, RUN=2'd3.
- One natural sub-module, byte_packer: handshake, phase bit, 16-bit assembly register, word-ready pulse.
- The FSM, counters and bus mux stay in boot_loader.

Test Plan:
1. Reset pulse mid-LOAD after 3 bytes → all outputs at reset values within the same cycle, state IDLE, nothing further written to sram.
2. start base=100, count=10, then 20 bytes 0x00,0x01..0x00,0x0A with valid held high → mem[100..109]=1..10, each WRITE spaced 3 cycles apart, o_done high and o_cpu_reset_n high one cycle later.
3. Same load with valid toggling every other cycle → identical mem contents; o_byte_ready low in every WRITE cycle; no byte lost or duplicated.
4. start base=4090, count=7 → o_error=1, state stays IDLE, o_mem_we never asserted. Then start base=4090, count=6 → o_error clears, 6 words written to 4090..4095.
5. start count=0 → RUN next cycle with zero sram writes. Then CPU drives addr=99, data=55, we=1, ce=1 → sram mem[99]=55.
6. Second i_start during LOAD (base=0) → ignored; load completes at the original base; address 0 untouched.
